mtm_alu_serializer: RTL and testbench
=====================================

Name: mtm_alu_serializer

Overview:
- Downstream stage of the ALU core.
- Captures the core's 32-bit result, 4-bit ALU flags and 3-bit error flags on a single-cycle valid strobe.
- Transmits the captured result as 11-bit serial frames on `sout`, which idles high.
- Normal result: four DATA frames plus one CTL frame. Error result: a single CTL frame.

Parameters:
- CLKS_PER_BIT, default 1: clock cycles per serial bit. Legal range 1..255.

Ports:
- clk  input  1  system clock, posedge active
- rst_n  input  1  synchronous reset, active low
- C_in  input  32  ALU result from core
- flg_in  input  4  ALU flags {carry, overflow, zero, negative}
- err_flg_in  input  3  error flags {data, crc, op}; 3'b000 means no error
- data_valid  input  1  single-cycle strobe: C_in, flg_in, err_flg_in are valid
- sout  output  1  serial output, idle high
- busy  output  1  high while a response is latched or being transmitted

Behaviour:
- Clock and reset: one clock `clk`, posedge active. Reset `rst_n` is synchronous and active low.
- Reset values: sout=1, busy=0, state=IDLE, all counters and latches 0.
- Reset asserted mid-transmission: the transmission is aborted. Next cycle sout=1, busy=0, no partial frame is resumed.
- Frame format, 11 bits, sent first to last: start 0, type bit (0=DATA, 1=CTL), byte bits b7..b0 (MSB first), stop 1. Each bit is held for CLKS_PER_BIT cycles.
- Accept rule:
  - data_valid is sampled only when busy=0. On acceptance, inputs are latched and busy=1 from the next cycle.
  - data_valid while busy=1 is dropped: no queuing, no effect on the current transmission.
- Latency: the start bit of the first frame appears on sout in the cycle after acceptance.
- Normal response (err_flg_in==0):
  - DATA frames carrying C[31:24], C[23:16], C[15:8], C[7:0], in that order.
  - Then a CTL frame with byte {1'b0, flg[3:0], crc[2:0]}.
  - Total 55 bit periods.
- CRC:
  - CRC-3, polynomial x^3+x+1, init 3'b000, no final XOR.
  - Computed over the 37-bit vector {C[31:0], 1'b0, flg[3:0]}, MSB first.
  - Computed from the latched values. Combinational or iterative implementation allowed, provided the CTL byte is ready before its frame starts.
- Error response (err_flg_in!=0):
  - One CTL frame, byte {1'b1, err[2:0], err[2:0], par}, where par = XOR of the other 7 bits, giving even parity over the byte.
  - Total 11 bit periods.
  - Error takes precedence: C_in and flg_in are ignored.
  - Multiple error bits set: transmitted as given, no prioritisation.
- FSM:
  - IDLE: on accepted data_valid -> START.
  - START -> TYPE -> DATA (8 bits, bit counter 7..0) -> STOP.
  - STOP: if frames remain -> START, else -> IDLE.
- Counters:
  - Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps.
  - Frame counter counts 0..4 for normal responses; fixed at 1 frame for error responses.
- Back-to-back responses: busy drops in the cycle after the last stop-bit period ends. A data_valid in that same cycle is accepted, so the minimum gap between responses is 1 idle cycle.
- Frames within one response are contiguous: no idle bits between stop and the next start, unless the optional feature is enabled.

Optional Feature:
- Macro MTM_SER_INTERFRAME_GAP_EN.
- Defined: one idle-high bit period (CLKS_PER_BIT cycles) is inserted after every stop bit except the last of a response. A normal response takes 59 bit periods; an error response is unchanged.
- Undefined: frames are contiguous, as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with data_valid toggling -> sout=1, busy=0 throughout.
- Normal response: CLKS_PER_BIT=1, C_in=32'h01020304, flg_in=4'b0000, err=0, one-cycle valid -> sout shows DATA 8'h01, 8'h02, 8'h03, 8'h04, then CTL {0,0000,crc} with crc matching the bench CRC-3 model. busy is high for exactly 55 cycles.
- Error response: err_flg_in=3'b100 -> single frame 0,1,1,1,0,0,1,0,0,1,1 (byte 8'hC9). err=3'b010 -> byte 8'hA5. err=3'b001 -> byte 8'h93. busy is high for 11 cycles.
- Busy drop: second data_valid pulse with C_in=32'hFFFFFFFF asserted mid-transmission -> ignored; the output stream is identical to a single response and no second response follows.
- Reset mid-operation and back-to-back:
  - rst_n=0 during the third DATA frame -> sout=1 and busy=0 on the next cycle.
  - Afterwards, data_valid in the first cycle busy=0 -> new response starts correctly.
- Timing: CLKS_PER_BIT=4, C_in=32'hDEADBEEF, flg_in=4'b1001 -> each bit held exactly 4 cycles, 220 busy cycles. With MTM_SER_INTERFRAME_GAP_EN defined -> 236 busy cycles.

Source files
------------

// File: rtl/mtm_alu_serializer.sv
// Serialises one ALU core response into 11-bit start/type/byte/stop frames on sout.
// Optional MTM_SER_INTERFRAME_GAP_EN inserts one idle-high bit period between frames.
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] C_in,
  input  logic [3:0]  flg_in,
  input  logic [2:0]  err_flg_in,
  input  logic        data_valid,
  output logic        sout,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TYPE, S_DATA, S_STOP, S_GAP
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0] c_q, c_d;
  logic [3:0]  flg_q, flg_d;
  logic [2:0]  err_q, err_d;

  logic       is_err, last_frame, bit_end, type_bit;
  logic [2:0] crc;
  logic [7:0] frame_byte;

  // Bitwise CRC-3 (x^3+x+1), MSB first, zero init.
  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] r;
    logic       fb;
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ v[i];
      r  = {r[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return r;
  endfunction

  assign is_err     = |err_q;
  assign last_frame = is_err || (frame_cnt_q == 3'd4);
  assign bit_end    = (clk_cnt_q == CNT_LAST);
  assign crc        = crc3({c_q, 1'b0, flg_q});
  // The CTL frame is always the last one of a response, both normal and error.
  assign type_bit   = last_frame;

  always_comb begin
    frame_byte = {1'b0, flg_q, crc};
    if (is_err) begin
      frame_byte = {1'b1, err_q, err_q, ^{1'b1, err_q, err_q}};
    end else begin
      case (frame_cnt_q)
        3'd0:    frame_byte = c_q[31:24];
        3'd1:    frame_byte = c_q[23:16];
        3'd2:    frame_byte = c_q[15:8];
        3'd3:    frame_byte = c_q[7:0];
        default: frame_byte = {1'b0, flg_q, crc};
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    clk_cnt_d   = (state_q == S_IDLE) ? 8'd0 : (bit_end ? 8'd0 : clk_cnt_q + 8'd1);
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    c_d         = c_q;
    flg_d       = flg_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d     = S_START;
          frame_cnt_d = 3'd0;
          bit_cnt_d   = 3'd7;
          c_d         = C_in;
          flg_d       = flg_in;
          err_d       = err_flg_in;
        end
      end
      S_START: if (bit_end) state_d = S_TYPE;
      S_TYPE: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd7;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = S_STOP;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_frame) begin
            state_d = S_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 3'd1;
`ifdef MTM_SER_INTERFRAME_GAP_EN
            state_d = S_GAP;
`else
            state_d = S_START;
`endif
          end
        end
      end
      S_GAP: if (bit_end) state_d = S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sout = 1'b1;
    case (state_q)
      S_START: sout = 1'b0;
      S_TYPE:  sout = type_bit;
      S_DATA:  sout = frame_byte[bit_cnt_q];
      default: sout = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only; the latched
  // operands are reset too, so no stale response data survives a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= 8'd0;
      bit_cnt_q   <= 3'd0;
      frame_cnt_q <= 3'd0;
      c_q         <= 32'd0;
      flg_q       <= 4'd0;
      err_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      c_q         <= c_d;
      flg_q       <= flg_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: one instance at 1 clock/bit, one at 4.
// Expected serial traces come from a frame-level model of the response format.
module tb_mtm_alu_serializer;

`ifdef MTM_SER_INTERFRAME_GAP_EN
  localparam int NORM_BP = 59;
  localparam bit GAP_EN  = 1'b1;
`else
  localparam int NORM_BP = 55;
  localparam bit GAP_EN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_in = '0;
  logic [3:0]  flg_in = '0;
  logic [2:0]  err_in = '0;
  logic        dv_a = 1'b0, dv_b = 1'b0;
  logic        sout_a, busy_a, sout_b, busy_b;

  always #5 clk = ~clk;

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .C_in(c_in), .flg_in(flg_in), .err_flg_in(err_in),
    .data_valid(dv_a), .sout(sout_a), .busy(busy_a)
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .C_in(c_in), .flg_in(flg_in), .err_flg_in(err_in),
    .data_valid(dv_b), .sout(sout_b), .busy(busy_b)
  );

  typedef struct {
    logic [0:4][7:0] b;
    logic [0:4]      typ;
    int              n;
  } resp_t;

  typedef struct {
    int          sel;
    logic [31:0] c;
    logic [3:0]  f;
    logic [2:0]  e;
    resp_t       exp;
    int          busy;
  } vec_t;

  int checks = 0;
  int failures = 0;
  bit trace_q[$];
  bit exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 1 : 4;
  endfunction

  function automatic logic cur_sout(input int sel);
    return (sel == 0) ? sout_a : sout_b;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic set_dv(input int sel, input logic v);
    if (sel == 0) dv_a = v;
    else          dv_b = v;
  endtask

  // CRC as the remainder of polynomial long division of v*x^3 by x^3+x+1.
  function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic resp_t model_resp(input logic [31:0] c, input logic [3:0] f,
                                       input logic [2:0] e);
    resp_t      r;
    logic [6:0] hi;
    r.b   = '0;
    r.typ = '0;
    if (e != 3'b000) begin
      hi       = {1'b1, e, e};
      r.b[0]   = {hi, 1'($countones(hi) % 2)};
      r.typ[0] = 1'b1;
      r.n      = 1;
    end else begin
      for (int i = 0; i < 4; i++) r.b[i] = 8'((c >> (8 * (3 - i))) & 32'hFF);
      r.b[4]   = {1'b0, f, model_crc(c, f)};
      r.typ[4] = 1'b1;
      r.n      = 5;
    end
    return r;
  endfunction

  task automatic build_trace(input resp_t r, input int cpb);
    logic [10:0] fv;
    exp_q.delete();
    for (int fr = 0; fr < r.n; fr++) begin
      fv = {1'b0, r.typ[fr], r.b[fr], 1'b1};
      for (int j = 10; j >= 0; j--)
        for (int k = 0; k < cpb; k++) exp_q.push_back(fv[j]);
      if (GAP_EN && fr < r.n - 1)
        for (int k = 0; k < cpb; k++) exp_q.push_back(1'b1);
    end
  endtask

  // Strobes one response into the selected instance and records sout while busy.
  // A second strobe with different data is injected at sample index drop_at (if >= 0).
  task automatic do_resp(input string tag, input int sel, input logic [31:0] c,
                         input logic [3:0] f, input logic [2:0] e, input resp_t r,
                         input int drop_at, input int exp_busy);
    int mism;
    c_in = c; flg_in = f; err_in = e;
    set_dv(sel, 1'b1);
    @(posedge clk);
    #1 set_dv(sel, 1'b0);
    trace_q.delete();
    forever begin
      @(negedge clk);
      if (!cur_busy(sel)) break;
      if (trace_q.size() == drop_at) begin
        c_in = 32'hFFFF_FFFF; err_in = 3'b000; set_dv(sel, 1'b1);
      end else if (trace_q.size() == drop_at + 1) begin
        set_dv(sel, 1'b0); c_in = c; err_in = e;
      end
      trace_q.push_back(cur_sout(sel));
      if (trace_q.size() > 3000) begin
        check({tag, " busy_timeout"}, 1, 0);
        break;
      end
    end
    set_dv(sel, 1'b0);
    build_trace(r, cpb_of(sel));
    check({tag, " busy_cycles"}, trace_q.size(), exp_busy);
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
      if (trace_q[i] !== exp_q[i]) mism++;
    check({tag, " sout_bit_errors"}, mism, 0);
  endtask

  vec_t  vecs[6];
  resp_t r;

  initial begin
    vecs[0] = '{0, 32'h0102_0304, 4'b0000, 3'b000,
                '{{8'h01, 8'h02, 8'h03, 8'h04, {1'b0, 4'b0000, model_crc(32'h0102_0304, 4'b0000)}},
                  5'b00001, 5}, NORM_BP};
    vecs[1] = '{0, 32'h1234_5678, 4'b1111, 3'b100, '{{8'hC9, 32'h0}, 5'b10000, 1}, 11};
    vecs[2] = '{0, 32'h0, 4'b0000, 3'b010, '{{8'hA5, 32'h0}, 5'b10000, 1}, 11};
    vecs[3] = '{0, 32'hFFFF_FFFF, 4'b0101, 3'b001, '{{8'h93, 32'h0}, 5'b10000, 1}, 11};
    vecs[4] = '{1, 32'hDEAD_BEEF, 4'b1001, 3'b000,
                '{{8'hDE, 8'hAD, 8'hBE, 8'hEF, {1'b0, 4'b1001, model_crc(32'hDEAD_BEEF, 4'b1001)}},
                  5'b00001, 5}, NORM_BP * 4};
    vecs[5] = '{1, 32'hDEAD_BEEF, 4'b1001, 3'b111, '{{8'hFF, 32'h0}, 5'b10000, 1}, 44};

    // Reset held for 3 cycles with data_valid toggling.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 dv_a = i[0]; dv_b = ~i[0];
      @(negedge clk);
      check($sformatf("reset%0d sout_a", i), sout_a, 1);
      check($sformatf("reset%0d busy_a", i), busy_a, 0);
      check($sformatf("reset%0d busy_b", i), busy_b, 0);
      @(posedge clk);
    end
    #1 dv_a = 1'b0; dv_b = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post_reset busy_a", busy_a, 0);

    foreach (vecs[i])
      do_resp($sformatf("vec%0d", i), vecs[i].sel, vecs[i].c, vecs[i].f, vecs[i].e,
              vecs[i].exp, -1, vecs[i].busy);

    // Strobe during transmission must be dropped with no trailing response.
    r = model_resp(32'hCAFE_0042, 4'b0110, 3'b000);
    do_resp("drop", 0, 32'hCAFE_0042, 4'b0110, 3'b000, r, 20, NORM_BP);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drop idle%0d busy", i), busy_a, 0);
    end

    // Reset during the third DATA frame, then a strobe in the first idle cycle.
    c_in = 32'h0102_0304; flg_in = 4'b0000; err_in = 3'b000;
    dv_a = 1'b1;
    @(posedge clk);
    #1 dv_a = 1'b0;
    repeat (26) @(negedge clk);
    check("midrst busy_before", busy_a, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst sout", sout_a, 1);
    check("midrst busy", busy_a, 0);
    r = model_resp(32'h89AB_CDEF, 4'b1010, 3'b000);
    do_resp("after_rst", 0, 32'h89AB_CDEF, 4'b1010, 3'b000, r, -1, NORM_BP);

    // Randomised back-to-back responses against the frame model.
    for (int i = 0; i < 16; i++) begin
      int          sel;
      logic [31:0] c;
      logic [3:0]  f;
      logic [2:0]  e;
      sel = int'($urandom_range(0, 1));
      c   = $urandom;
      f   = 4'($urandom);
      e   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      r   = model_resp(c, f, e);
      do_resp($sformatf("rand%0d", i), sel, c, f, e, r, -1,
              (e != 3'b000 ? 11 : NORM_BP) * cpb_of(sel));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
